// File: rtl/sim_sequencer.sv
// sim_sequencer: pausable/steppable run sequencer WARMUP -> MEASURE -> DRAIN -> DONE with cycle counters
module sim_sequencer #(
  parameter int CYCLE_WIDTH    = 16,
  parameter int WARMUP_CYCLES  = 4,
  parameter int MEASURE_CYCLES = 8,
  parameter int DRAIN_LIMIT    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   step,
  input  logic                   net_empty,
  output logic [2:0]             state,
  output logic [CYCLE_WIDTH-1:0] current_cycle,
  output logic [CYCLE_WIDTH-1:0] phase_cycle,
  output logic                   measure_en,
  output logic                   done,
  output logic                   timeout
);
  typedef enum logic [2:0] {IDLE, WARMUP, MEASURE, DRAIN, DONE} state_t;
  localparam logic [CYCLE_WIDTH-1:0] W_LAST = CYCLE_WIDTH'(WARMUP_CYCLES - 1);
  localparam logic [CYCLE_WIDTH-1:0] M_LAST = CYCLE_WIDTH'(MEASURE_CYCLES - 1);
  localparam logic [CYCLE_WIDTH-1:0] D_LAST = CYCLE_WIDTH'(DRAIN_LIMIT - 1);
  state_t cur, nxt;
  logic adv, active, launch, phase_end;
  assign adv    = !pause || step;
  assign active = cur == WARMUP || cur == MEASURE || cur == DRAIN;
  assign launch = (cur == IDLE || cur == DONE) && start;
  // A drained network wins over the drain limit on the same cycle
  assign phase_end = (cur == WARMUP && phase_cycle == W_LAST) ||
                     (cur == MEASURE && phase_cycle == M_LAST) ||
                     (cur == DRAIN && (net_empty || phase_cycle == D_LAST));
  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= IDLE;
    else cur <= nxt;
  // Next state: phases are encoded consecutively so a phase end steps to cur+1
  always_comb begin
    nxt = cur;
    if (launch) nxt = WARMUP;
    else if (active && adv && phase_end) nxt = state_t'(cur + 3'd1);
  end
  // Counters and timeout flag advance only on advanced cycles in an active phase
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      current_cycle <= '0;
      phase_cycle   <= '0;
      timeout       <= 1'b0;
    end else if (launch) begin
      current_cycle <= '0;
      phase_cycle   <= '0;
      timeout       <= 1'b0;
    end else if (active && adv) begin
      current_cycle <= &current_cycle ? current_cycle : current_cycle + CYCLE_WIDTH'(1);
      phase_cycle   <= phase_end ? '0 : phase_cycle + CYCLE_WIDTH'(1);
      timeout       <= cur == DRAIN && phase_end && !net_empty;
    end
  // Outputs; measure_en is combinational so a paused cycle never counts
  always_comb begin
    state      = cur;
    measure_en = cur == MEASURE && adv;
    done       = cur == DONE;
  end
endmodule

// File: tb/tb_sim_sequencer.sv
// tb_sim_sequencer: directed scoreboard bench for sim_sequencer (default and narrow-counter instances)
module tb_sim_sequencer;
  logic clk, reset, start, start_b, pause, step, net_empty, net_empty_b;
  logic [2:0] a_state, b_state;
  logic [15:0] a_cur, a_phase;
  logic [3:0] b_cur, b_phase;
  logic a_me, a_done, a_to, b_me, b_done, b_to;
  int total = 0, bad = 0, me_cnt = 0, m0;
  string tq[$];
  int vq[$];

  sim_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step), .net_empty(net_empty),
    .state(a_state), .current_cycle(a_cur), .phase_cycle(a_phase), .measure_en(a_me),
    .done(a_done), .timeout(a_to));

  sim_sequencer #(.CYCLE_WIDTH(4), .WARMUP_CYCLES(8), .MEASURE_CYCLES(8), .DRAIN_LIMIT(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pause(pause), .step(step), .net_empty(net_empty_b),
    .state(b_state), .current_cycle(b_cur), .phase_cycle(b_phase), .measure_en(b_me),
    .done(b_done), .timeout(b_to));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (a_me === 1'b1) me_cnt = me_cnt + 1;

  task tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task ex(input string t, input int v);
    tq.push_back(t);
    vq.push_back(v);
  endtask

  task ck(input int obs);
    string t;
    int v;
    total++;
    if (vq.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      t = tq.pop_front();
      v = vq.pop_front();
      assert (obs === v) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", t, obs, v);
      end
    end
  endtask

  task exa(input int st, input int cc);
    ex("a_state", st);
    ex("a_cur", cc);
  endtask

  task cka();
    ck(int'(a_state));
    ck(int'(a_cur));
  endtask

  task exb(input int st, input int cc);
    ex("b_state", st);
    ex("b_cur", cc);
  endtask

  task ckb();
    ck(int'(b_state));
    ck(int'(b_cur));
  endtask

  initial begin
    reset = 1; start = 0; start_b = 0; pause = 0; step = 0; net_empty = 1; net_empty_b = 0;
    exa(0, 0); ex("a_phase", 0); ex("a_done", 0); ex("a_timeout", 0); ex("a_me_en", 0);
    tick(2);
    cka(); ck(int'(a_phase)); ck(int'(a_done)); ck(int'(a_to)); ck(int'(a_me));
    reset = 0;
    // nominal run, step held high with pause low must not double-advance
    step = 1; start = 1; m0 = me_cnt;
    exa(1, 0); ex("a_phase", 0);
    tick(1); start = 0;
    cka(); ck(int'(a_phase));
    exa(2, 4); ex("a_phase", 0); tick(4); cka(); ck(int'(a_phase));
    exa(3, 12); tick(8); cka();
    exa(4, 13); ex("a_done", 1); ex("a_timeout", 0); ex("a_me_pulses", 8);
    tick(1);
    cka(); ck(int'(a_done)); ck(int'(a_to)); ck(me_cnt - m0);
    step = 0;
    exa(4, 13); ex("a_done", 1); tick(3); cka(); ck(int'(a_done));
    // drain timeout run
    net_empty = 0; start = 1;
    exa(1, 0); ex("a_done", 0); ex("a_timeout", 0);
    tick(1); start = 0;
    cka(); ck(int'(a_done)); ck(int'(a_to));
    exa(3, 12); tick(12); cka();
    exa(3, 27); ex("a_phase", 15); ex("a_timeout", 0); tick(15); cka(); ck(int'(a_phase)); ck(int'(a_to));
    exa(4, 28); ex("a_timeout", 1); ex("a_done", 1); tick(1); cka(); ck(int'(a_to)); ck(int'(a_done));
    // pause and single-step in WARMUP, then pause mid-MEASURE
    net_empty = 1; start = 1; m0 = me_cnt;
    exa(1, 0); ex("a_timeout", 0);
    tick(1); start = 0;
    cka(); ck(int'(a_to));
    pause = 1;
    exa(1, 0); ex("a_phase", 0); tick(2); cka(); ck(int'(a_phase));
    exa(1, 3); ex("a_phase", 3);
    repeat (3) begin
      step = 1; tick(1); step = 0; tick(1);
    end
    cka(); ck(int'(a_phase));
    pause = 0;
    exa(2, 4); tick(1); cka();
    exa(2, 7); ex("a_me_pulses", 3); tick(3); cka(); ck(me_cnt - m0);
    pause = 1;
    exa(2, 7); ex("a_phase", 3); ex("a_me_pulses", 3); ex("a_me_en", 0);
    tick(5);
    cka(); ck(int'(a_phase)); ck(me_cnt - m0); ck(int'(a_me));
    pause = 0;
    exa(3, 12); tick(5); cka();
    exa(4, 13); ex("a_me_pulses", 8); tick(1); cka(); ck(me_cnt - m0);
    // asynchronous reset mid-MEASURE, start ignored while reset is high
    start = 1; exa(1, 0); tick(1); start = 0; cka();
    exa(2, 6); tick(6); cka();
    #2; reset = 1; start = 1;
    exa(0, 0); ex("a_phase", 0); ex("a_me_en", 0); ex("a_done", 0);
    #1;
    cka(); ck(int'(a_phase)); ck(int'(a_me)); ck(int'(a_done));
    exa(0, 0); tick(2); cka();
    start = 0; reset = 0;
    exa(0, 0); tick(2); cka();
    start = 1; exa(1, 0); tick(1); start = 0; cka();
    reset = 1; tick(1); reset = 0;
    // narrow counters: saturation and restart
    start_b = 1; exb(1, 0); tick(1); start_b = 0; ckb();
    exb(2, 8); tick(8); ckb();
    exb(3, 15); tick(8); ckb();
    exb(3, 15); ex("b_phase", 7); ex("b_timeout", 0); tick(7); ckb(); ck(int'(b_phase)); ck(int'(b_to));
    exb(4, 15); ex("b_timeout", 1); ex("b_done", 1); tick(1); ckb(); ck(int'(b_to)); ck(int'(b_done));
    start_b = 1; exb(1, 0); ex("b_timeout", 0); tick(1); start_b = 0; ckb(); ck(int'(b_to));
    exb(1, 3); ex("b_phase", 3); tick(3); ckb(); ck(int'(b_phase));
    if (vq.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", vq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sim_sequencer.md
SIM_SEQUENCER -- requirements
Module: sim_sequencer

Interface
REQ-001 SHALL have parameter CYCLE_WIDTH, default 16, width of all cycle counters.
REQ-002 SHALL have parameter WARMUP_CYCLES, default 4, advanced cycles spent in WARMUP (legal 1 .. 2^CYCLE_WIDTH-1).
REQ-003 SHALL have parameter MEASURE_CYCLES, default 8, advanced cycles spent in MEASURE (same legal range).
REQ-004 SHALL have parameter DRAIN_LIMIT, default 16, maximum advanced cycles in DRAIN before timeout (same legal range).
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle run request.
REQ-008 SHALL have port pause, input, 1, level; freezes sequencing while high.
REQ-009 SHALL have port step, input, 1, single-cycle request to advance one cycle while paused.
REQ-010 SHALL have port net_empty, input, 1, high when the simulated network holds no traffic.
REQ-011 SHALL have port state, output, 3, encoding IDLE=0, WARMUP=1, MEASURE=2, DRAIN=3, DONE=4.
REQ-012 SHALL have port current_cycle, output, CYCLE_WIDTH, total advanced cycles since the last run start.
REQ-013 SHALL have port phase_cycle, output, CYCLE_WIDTH, advanced cycles since entry to the current phase.
REQ-014 SHALL have port measure_en, output, 1, statistics-collection strobe.
REQ-015 SHALL have ports done and timeout, output, 1 each, run-complete flag and drain-timeout flag.

Function
REQ-016 SHALL define adv = (!pause || step); only cycles with adv=1 are "advanced" cycles.
REQ-017 SHALL, in IDLE or DONE with start=1, move to WARMUP next edge, clearing current_cycle, phase_cycle, done and timeout; start SHALL be ignored in all other states.
REQ-018 SHALL, in WARMUP/MEASURE/DRAIN with adv=1, increment current_cycle and phase_cycle by 1 each edge; with adv=0 all state and counters SHALL hold.
REQ-019 SHALL saturate current_cycle at 2^CYCLE_WIDTH-1 (no wrap); phase_cycle never exceeds its phase limit.
REQ-020 SHALL, in WARMUP with adv=1 and phase_cycle==WARMUP_CYCLES-1, move to MEASURE with phase_cycle cleared to 0.
REQ-021 SHALL, in MEASURE with adv=1 and phase_cycle==MEASURE_CYCLES-1, move to DRAIN with phase_cycle cleared to 0.
REQ-022 SHALL drive measure_en combinationally = (state==MEASURE && adv), so it pulses exactly MEASURE_CYCLES times per run regardless of pausing.
REQ-023 SHALL, in DRAIN with adv=1 and net_empty=1, move to DONE with timeout=0; net_empty takes priority over the limit on the same cycle.
REQ-024 SHALL, in DRAIN with adv=1, net_empty=0 and phase_cycle==DRAIN_LIMIT-1, move to DONE with timeout=1.
REQ-025 SHALL hold DONE with done=1, counters frozen, until start or reset.
REQ-026 SHALL treat step while pause=0 as no extra effect (one advance per edge maximum).

Reset
REQ-027 SHALL, on reset high, immediately (asynchronously) set state=IDLE, current_cycle=0, phase_cycle=0, done=0, timeout=0, regardless of phase or pause.
REQ-028 SHALL hold measure_en=0 throughout reset; start/step SHALL be ignored while reset is high.
REQ-029 SHALL resume normal operation on the first rising clk after reset deasserts.

Verification
REQ-030 Defaults, pause=0, net_empty=1, start pulse -> 4 cycles WARMUP, 8 measure_en pulses, 1 DRAIN cycle, DONE with current_cycle=13, timeout=0.
REQ-031 Defaults, net_empty=0 always -> DRAIN lasts 16 cycles, DONE with timeout=1, current_cycle=28.
REQ-032 pause=1 for 5 cycles mid-MEASURE -> state, both counters hold, measure_en=0; after release total measure_en pulses still 8.
REQ-033 pause=1 in WARMUP plus 3 step pulses -> phase_cycle and current_cycle each rise by exactly 3.
REQ-034 reset asserted mid-MEASURE (between clock edges) -> outputs reach IDLE/zero values before the next edge; start ignored until reset drops.
REQ-035 CYCLE_WIDTH=4, WARMUP=8, MEASURE=8, DRAIN_LIMIT=8, net_empty=0 -> current_cycle saturates at 15, DONE with timeout=1; a second start restarts from 0.
